fifo_w_ctrl: RTL

Write-side controller of the FIFO, directly upstream of the read-side FSM.
- Accepts write requests from the producer, registers the write data and issues a single-cycle push strobe plus write address to the memory.
- Compares its write pointer against the reader's pointer and generates Full (used internally) and Empty (consumed by the read FSM).
- Full/Empty logic uses the same (DEEP+1)-bit wrap-bit pointer scheme as the reader.

---
 rtl/fifo_w_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fifo_w_ctrl.sv
// Write-side FIFO controller: accepts producer words, issues push strobe + write pointer, derives Full/Empty.
// Latency: word accepted in cycle N is pushed (push=1, wr_data) in N+1; address advances in N+2.
// Backpressure: accept is dropped combinationally whenever the pending write would leave the FIFO full.
// Optional build macro FIFO_W_OVF_EN adds a sticky overflow flag and a saturating reject counter.
module fifo_w_ctrl #(
    parameter int DEEP  = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic [DEEP:0]    rd_address,
    output logic             accept,
    output logic             push,
    output logic [DEEP:0]    address,
    output logic [WIDTH-1:0] wr_data,
    output logic             Full,
    output logic             Empty
`ifdef FIFO_W_OVF_EN
    ,
    output logic             ovf,
    output logic [7:0]       ovf_cnt
`endif
);

    // State encoding kept as plain constants so the 2-bit codes stay visible
    // to the read-side FSM designers; 2'b11 is unused and recovers to WAIT.
    localparam logic [1:0] ST_WAIT = 2'd0;
    localparam logic [1:0] ST_FULL = 2'd1;
    localparam logic [1:0] ST_PUSH = 2'd2;

    localparam logic [DEEP:0] PTR_ONE = {{DEEP{1'b0}}, 1'b1};

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [DEEP:0]    addr_q;
    logic [DEEP:0]    addr_d;
    logic [WIDTH-1:0] wr_data_q;
    logic [WIDTH-1:0] wr_data_d;
    logic [DEEP:0]    addr_inc;
    logic             full_nx;

    // Pointers are equal in the index bits but differ in the wrap bit when
    // the writer is exactly one lap ahead of the reader.
    function automatic logic ptr_full(input logic [DEEP:0] wp, input logic [DEEP:0] rp);
        return (wp[DEEP] != rp[DEEP]) && (wp[DEEP-1:0] == rp[DEEP-1:0]);
    endfunction

    assign addr_inc = addr_q + PTR_ONE;

    // Status flags reflect only committed writes (registered pointer).
    always_comb begin
        Full  = ptr_full(addr_q, rd_address);
        Empty = (addr_q == rd_address);
    end

    // Look-ahead fullness: a push in flight this cycle counts as already written.
    always_comb begin
        full_nx = Full;
        if (state_q == ST_PUSH) begin
            full_nx = ptr_full(addr_inc, rd_address);
        end
    end

    // Producer handshake and the data register's next value.
    always_comb begin
        accept    = en & ~full_nx;
        wr_data_d = wr_data_q;
        if (accept) begin
            wr_data_d = din;
        end
    end

    // Next-state decision is the same from every legal state; the unused code recovers to WAIT.
    always_comb begin
        state_d = ST_WAIT;
        case (state_q)
            ST_WAIT, ST_FULL, ST_PUSH: begin
                if (full_nx) begin
                    state_d = ST_FULL;
                end else if (en) begin
                    state_d = ST_PUSH;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // The write pointer commits the word being pushed this cycle.
    always_comb begin
        addr_d = addr_q;
        if (state_q == ST_PUSH) begin
            addr_d = addr_inc;
        end
    end

    // State, pointer and data registers; reset drops any pending push uncommitted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_WAIT;
            addr_q    <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign push    = (state_q == ST_PUSH);
    assign address = addr_q;
    assign wr_data = wr_data_q;

`ifdef FIFO_W_OVF_EN
    logic       ovf_q;
    logic [7:0] ovf_cnt_q;
    logic       reject;

    assign reject = en & ~accept;

    // Sticky overflow flag and saturating count of producer cycles that were refused.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= 8'd0;
        end else if (reject) begin
            ovf_q <= 1'b1;
            if (ovf_cnt_q != 8'hFF) begin
                ovf_cnt_q <= ovf_cnt_q + 8'd1;
            end
        end
    end

    assign ovf     = ovf_q;
    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule
